// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and instruction field positions shared by the CPU control path.
// Revision 1.0
`default_nettype none

package cpu_pkg;

  localparam logic [5:0] c_OP_NOOP = 6'b000000;
  localparam logic [5:0] c_OP_MOVE = 6'b010000;
  localparam logic [5:0] c_OP_ADD  = 6'b010010;
  localparam logic [5:0] c_OP_SUB  = 6'b010011;
  localparam logic [5:0] c_OP_OR   = 6'b010100;
  localparam logic [5:0] c_OP_AND  = 6'b010101;
  localparam logic [5:0] c_OP_ADDI = 6'b110010;
  localparam logic [5:0] c_OP_SUBI = 6'b110011;
  localparam logic [5:0] c_OP_ORI  = 6'b110100;
  localparam logic [5:0] c_OP_ANDI = 6'b110101;
  localparam logic [5:0] c_OP_BEQ  = 6'b100000;
  localparam logic [5:0] c_OP_LI   = 6'b111001;
  localparam logic [5:0] c_OP_LWI  = 6'b111011;
  localparam logic [5:0] c_OP_SWI  = 6'b111100;

  localparam int c_OP_LSB  = 26;
  localparam int c_RD_LSB  = 21;
  localparam int c_RS_LSB  = 16;
  localparam int c_RT_LSB  = 11;
  localparam int c_IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  function automatic logic writes_rd(input logic [5:0] op);
    case (op)
      c_OP_MOVE, c_OP_ADD, c_OP_SUB, c_OP_OR, c_OP_AND,
      c_OP_ADDI, c_OP_SUBI, c_OP_ORI, c_OP_ANDI,
      c_OP_LI, c_OP_LWI: writes_rd = 1'b1;
      default:           writes_rd = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREG x DW registers, two combinational read ports, one synchronous write port.
// Revision 1.0
`default_nettype none

module cpu_regfile #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute/memory/write-back controller for an external ALU.
// Revision 1.0
`default_nettype none

module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [DW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [5:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_zero,
  output logic          retire,
  output logic [DW-1:0] pc
);

  localparam int AW = $clog2(NREG);

  state_e        state_q;
  logic [DW-1:0] pc_q;
  logic [31:0]   ir_q;
  logic [DW-1:0] res_q;
  logic          zero_q;
  logic [DW-1:0] ld_q;
  logic [DW-1:0] sd_q;

  logic [5:0]    op;
  logic [AW-1:0] rd_idx, rs_idx, rt_idx;
  logic [15:0]   imm;
  logic [DW-1:0] imm_s, imm_z;
  logic [AW-1:0] rf_ra_a, rf_ra_b;
  logic [DW-1:0] rf_rd_a, rf_rd_b;
  logic          rf_we;
  logic [DW-1:0] rf_wd;
  logic [5:0]    dec_op;
  logic [DW-1:0] dec_a, dec_b;
  logic [DW-1:0] pc_next;
  logic          is_mem;

  assign op     = ir_q[c_OP_LSB +: 6];
  assign rd_idx = ir_q[c_RD_LSB +: AW];
  assign rs_idx = ir_q[c_RS_LSB +: AW];
  assign rt_idx = ir_q[c_RT_LSB +: AW];
  assign imm    = ir_q[c_IMM_LSB +: 16];
  assign imm_s  = {{(DW-16){imm[15]}}, imm};
  assign imm_z  = {{(DW-16){1'b0}}, imm};
  assign is_mem = (op == c_OP_LWI) || (op == c_OP_SWI);

  // BEQ compares R[rd] with R[rs]; SWI stores R[rd]; everything else reads rs/rt.
  assign rf_ra_a = ((op == c_OP_BEQ) || (op == c_OP_SWI)) ? rd_idx : rs_idx;
  assign rf_ra_b = (op == c_OP_BEQ) ? rs_idx : rt_idx;

  assign rf_we = (state_q == S_WB) && writes_rd(op);
  assign rf_wd = (op == c_OP_LWI) ? ld_q : res_q;

  assign pc_next = (op == c_OP_BEQ && zero_q) ? pc_q + DW'(1) + imm_s : pc_q + DW'(1);
  assign pc      = pc_q;

  cpu_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rf_ra_a),
    .raddr_b_i (rf_ra_b),
    .rdata_a_o (rf_rd_a),
    .rdata_b_o (rf_rd_b),
    .we_i      (rf_we),
    .waddr_i   (rd_idx),
    .wdata_i   (rf_wd)
  );

  always_comb begin
    dec_op = c_OP_NOOP;
    dec_a  = '0;
    dec_b  = '0;
    case (op)
      c_OP_MOVE: begin
        dec_op = op; dec_a = rf_rd_a;
      end
      c_OP_ADD, c_OP_SUB, c_OP_OR, c_OP_AND, c_OP_BEQ: begin
        dec_op = op; dec_a = rf_rd_a; dec_b = rf_rd_b;
      end
      c_OP_ADDI, c_OP_SUBI, c_OP_ORI, c_OP_ANDI: begin
        dec_op = op; dec_a = rf_rd_a; dec_b = imm_s;
      end
      c_OP_LI: begin
        dec_op = op; dec_b = imm_s;
      end
      c_OP_LWI, c_OP_SWI: begin
        dec_op = op; dec_a = imm_z;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RESET;
      pc_q       <= '0;
      ir_q       <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ld_q       <= '0;
      sd_q       <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      alu_op     <= c_OP_NOOP;
      alu_a      <= '0;
      alu_b      <= '0;
      retire     <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          imem_req  <= 1'b1;
          imem_addr <= pc_q;
          state_q   <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_q     <= imem_data[31:0];
            imem_req <= 1'b0;
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_op  <= dec_op;
          alu_a   <= dec_a;
          alu_b   <= dec_b;
          sd_q    <= rf_rd_a;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_q  <= alu_r;
          zero_q <= alu_zero;
          alu_op <= c_OP_NOOP;
          alu_a  <= '0;
          alu_b  <= '0;
          if (is_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= (op == c_OP_SWI);
            dmem_addr  <= (op == c_OP_LWI) ? alu_r : alu_a;
            dmem_wdata <= (op == c_OP_SWI) ? sd_q : '0;
            state_q    <= S_MEM;
          end else begin
            retire  <= 1'b1;
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            ld_q     <= dmem_rdata;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            retire   <= 1'b1;
            state_q  <= S_WB;
          end
        end
        S_WB: begin
          retire    <= 1'b0;
          pc_q      <= pc_next;
          imem_req  <= 1'b1;
          imem_addr <= pc_next;
          state_q   <= S_FETCH;
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed and randomized checks of cpu_control_fsm against an architectural model.
// Revision 1.0
`default_nettype none

module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_data = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_r, pc;
  logic        alu_zero, retire;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_control_fsm #(.DW(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_zero(alu_zero),
    .retire(retire), .pc(pc)
  );

  // Stand-in for the combinational ALU sitting next to the controller.
  always_comb begin
    alu_r = '0;
    case (alu_op)
      6'h10:               alu_r = alu_a;
      6'h12, 6'h32:        alu_r = alu_a + alu_b;
      6'h13, 6'h33, 6'h20: alu_r = alu_a - alu_b;
      6'h14, 6'h34:        alu_r = alu_a | alu_b;
      6'h15, 6'h35:        alu_r = alu_a & alu_b;
      6'h39:               alu_r = alu_b;
      6'h3B, 6'h3C:        alu_r = alu_a;
      default:             alu_r = '0;
    endcase
    alu_zero = (alu_r == 32'd0);
  end

  logic [31:0] dm  [256];
  logic [31:0] mdm [256];
  logic [31:0] mR  [32];
  logic [31:0] mpc;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, pc;
    bit          mem;
    logic        we;
    logic [31:0] daddr, wd;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, iaddr, pc;
    int          lat, dreq, retires;
    logic        we;
    logic [31:0] daddr, wd;
    bit          stable, leak, ok;
  } obs_t;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mR[i] = '0;
    mpc = '0;
  endfunction

  // Architectural effect of one instruction on the model state.
  function automatic void ref_step(input logic [31:0] ins, output exp_t e);
    logic [5:0]  op  = ins[31:26];
    logic [4:0]  rd  = ins[25:21];
    logic [4:0]  rs  = ins[20:16];
    logic [4:0]  rt  = ins[15:11];
    logic [31:0] sx  = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] zx  = {16'h0, ins[15:0]};
    logic [31:0] nxt = mpc + 1;
    e.op = 6'h00; e.a = '0; e.b = '0; e.pc = mpc;
    e.mem = 0; e.we = 1'b0; e.daddr = '0; e.wd = '0;
    case (op)
      6'h10: begin e.op = op; e.a = mR[rs]; mR[rd] = e.a; end
      6'h12, 6'h13, 6'h14, 6'h15, 6'h32, 6'h33, 6'h34, 6'h35: begin
        e.op = op; e.a = mR[rs];
        e.b  = op[5] ? sx : mR[rt];
        case (op[2:0])
          3'd2:    mR[rd] = e.a + e.b;
          3'd3:    mR[rd] = e.a - e.b;
          3'd4:    mR[rd] = e.a | e.b;
          default: mR[rd] = e.a & e.b;
        endcase
      end
      6'h39: begin e.op = op; e.b = sx; mR[rd] = sx; end
      6'h3B: begin e.op = op; e.a = zx; e.mem = 1; e.daddr = zx; mR[rd] = mdm[zx[7:0]]; end
      6'h3C: begin
        e.op = op; e.a = zx; e.mem = 1; e.we = 1'b1; e.daddr = zx; e.wd = mR[rd];
        mdm[zx[7:0]] = mR[rd];
      end
      6'h20: begin
        e.op = op; e.a = mR[rd]; e.b = mR[rs];
        if (e.a == e.b) nxt = mpc + 1 + sx;
      end
      default: ;
    endcase
    mpc = nxt;
  endfunction

  // Serves one instruction fetch and any data access, recording what the DUT presented.
  task automatic exec_instr(input logic [31:0] ins, input int iw, input int dw, output obs_t o);
    int  t = 0, ack_c = -1, iwc = 0, dwc = 0;
    bit  done = 0, dseen = 0;
    o.op = '0; o.a = '0; o.b = '0; o.iaddr = '0; o.pc = '0;
    o.lat = 0; o.dreq = 0; o.retires = 0; o.we = 1'b0; o.daddr = '0; o.wd = '0;
    o.stable = 1; o.leak = 0; o.ok = 1;
    while (imem_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (imem_req !== 1'b1) begin o.ok = 0; return; end
    o.iaddr = imem_addr;
    o.pc    = pc;
    for (int c = 0; c < 64 && !done; c++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (ack_c < 0) begin
        if (imem_req !== 1'b1 || imem_addr !== o.iaddr) o.stable = 0;
        if (iwc == iw) begin imem_ack = 1'b1; imem_data = ins; ack_c = c; end
        else iwc++;
      end
      if (ack_c >= 0 && c == ack_c + 2) begin
        o.op = alu_op; o.a = alu_a; o.b = alu_b;
      end else if ({alu_op, alu_a, alu_b} !== '0) begin
        o.leak = 1;
      end
      if (dmem_req === 1'b1) begin
        if (!dseen) begin o.we = dmem_we; o.daddr = dmem_addr; o.wd = dmem_wdata; dseen = 1; end
        else if ({dmem_we, dmem_addr, dmem_wdata} !== {o.we, o.daddr, o.wd}) o.stable = 0;
        o.dreq++;
        if (dwc == dw) begin
          dmem_ack   = 1'b1;
          dmem_rdata = dm[dmem_addr[7:0]];
          if (dmem_we) dm[dmem_addr[7:0]] = dmem_wdata;
        end else dwc++;
      end
      if (retire === 1'b1) begin o.retires++; o.lat = c + 1; done = 1; end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (!done) o.ok = 0;
    if (retire === 1'b1) o.retires++;
  endtask

  task automatic step(input logic [31:0] ins, input int iw, input int dw, output exp_t e, output obs_t o);
    ref_step(ins, e);
    exec_instr(ins, iw, dw, o);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, alu_op, alu_a, alu_b, retire, pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h dreq=%b alu_op=%h retire=%b pc=%h, want all 0",
               imem_req, imem_addr, dmem_req, alu_op, retire, pc);
    end
    rst = 1'b0;
    model_reset();
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_cycle_req: got %b want 0", imem_req); end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL first_fetch: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_li();
    exp_t e; obs_t o;
    step({6'h39, 5'd1, 5'd0, 16'h0005}, 0, 0, e, o);
    checks++;
    if (o.iaddr !== 32'd0 || o.lat != 4 || o.retires != 1) begin
      errors++; $display("FAIL li_timing: got addr=%h lat=%0d retires=%0d want 0/4/1", o.iaddr, o.lat, o.retires);
    end
    checks++;
    if (o.op !== 6'h39 || o.b !== 32'h5 || o.a !== 32'h0) begin
      errors++; $display("FAIL li_exec: got op=%h a=%h b=%h want 39/0/5", o.op, o.a, o.b);
    end
  endtask

  task automatic test_alu_ops();
    exp_t e; obs_t o;
    step({6'h39, 5'd2, 5'd0, 16'h0003}, 0, 0, e, o);
    step({6'h13, 5'd3, 5'd1, 5'd2, 11'd0}, 1, 0, e, o);
    checks++;
    if (o.op !== 6'h13 || o.a !== 32'd5 || o.b !== 32'd3 || o.iaddr !== 32'd2) begin
      errors++; $display("FAIL sub_operands: got op=%h a=%h b=%h pc=%h want 13/5/3/2", o.op, o.a, o.b, o.iaddr);
    end
    checks++;
    if (o.lat != 5) begin errors++; $display("FAIL fetch_wait_latency: got %0d want 5", o.lat); end
    step({6'h35, 5'd4, 5'd1, 16'hFFFC}, 0, 0, e, o);
    checks++;
    if (o.a !== 32'd5 || o.b !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL andi_operands: got a=%h b=%h want 5/fffffffc", o.a, o.b);
    end
    step({6'h10, 5'd9, 5'd3, 16'h0}, 0, 0, e, o);
    checks++;
    if (o.a !== 32'd2) begin errors++; $display("FAIL sub_result: got R3=%h want 2", o.a); end
    step({6'h10, 5'd9, 5'd4, 16'h0}, 0, 0, e, o);
    checks++;
    if (o.a !== 32'd4) begin errors++; $display("FAIL andi_result: got R4=%h want 4", o.a); end
  endtask

  task automatic test_branch();
    exp_t e; obs_t o;
    step({6'h39, 5'd1, 5'd0, 16'd7}, 0, 0, e, o);
    step({6'h39, 5'd5, 5'd0, 16'd7}, 0, 0, e, o);
    for (int i = 0; i < 16 && mpc != 32'd10; i++) step(32'h0, 0, 0, e, o);
    step({6'h20, 5'd1, 5'd5, 16'd4}, 0, 0, e, o);
    checks++;
    if (o.iaddr !== 32'd10 || o.a !== 32'd7 || o.b !== 32'd7 || o.lat != 4) begin
      errors++; $display("FAIL beq_exec: got pc=%h a=%h b=%h lat=%0d want a/7/7/4", o.iaddr, o.a, o.b, o.lat);
    end
    step({6'h39, 5'd5, 5'd0, 16'd8}, 0, 0, e, o);
    checks++;
    if (o.iaddr !== 32'd15) begin errors++; $display("FAIL beq_taken: got pc=%h want f", o.iaddr); end
    step({6'h20, 5'd1, 5'd1, 16'hFFF9}, 0, 0, e, o);
    step({6'h20, 5'd1, 5'd5, 16'd4}, 0, 0, e, o);
    checks++;
    if (o.iaddr !== 32'd10) begin errors++; $display("FAIL beq_backward: got pc=%h want a", o.iaddr); end
    step({6'h20, 5'd1, 5'd1, 16'hFFFE}, 0, 0, e, o);
    checks++;
    if (o.iaddr !== 32'd11) begin errors++; $display("FAIL beq_not_taken: got pc=%h want b", o.iaddr); end
    step({6'h20, 5'd1, 5'd1, 16'hFFFF}, 0, 0, e, o);
    step(32'h0, 0, 0, e, o);
    checks++;
    if (o.iaddr !== 32'd10 || o.pc !== 32'd10) begin
      errors++; $display("FAIL beq_self_loop: got imem_addr=%h pc=%h want a/a", o.iaddr, o.pc);
    end
  endtask

  task automatic test_mem();
    exp_t e; obs_t o;
    step({6'h39, 5'd1, 5'd0, 16'd5}, 0, 0, e, o);
    step({6'h3C, 5'd1, 5'd0, 16'h0020}, 0, 3, e, o);
    checks++;
    if (o.dreq != 4 || o.we !== 1'b1 || o.daddr !== 32'h20 || o.wd !== 32'd5 || !o.stable) begin
      errors++; $display("FAIL swi_access: got cycles=%0d we=%b addr=%h wdata=%h stable=%0d want 4/1/20/5/1",
                         o.dreq, o.we, o.daddr, o.wd, o.stable);
    end
    checks++;
    if (o.lat != 8) begin errors++; $display("FAIL swi_latency: got %0d want 8", o.lat); end
    step({6'h3B, 5'd6, 5'd0, 16'h0020}, 0, 3, e, o);
    checks++;
    if (o.lat != 8 || o.we !== 1'b0 || o.daddr !== 32'h20) begin
      errors++; $display("FAIL lwi_access: got lat=%0d we=%b addr=%h want 8/0/20", o.lat, o.we, o.daddr);
    end
    step({6'h10, 5'd9, 5'd6, 16'h0}, 0, 0, e, o);
    checks++;
    if (o.a !== 32'd5) begin errors++; $display("FAIL lwi_result: got R6=%h want 5", o.a); end
  endtask

  task automatic test_noop();
    exp_t e; obs_t o;
    logic [31:0] ins;
    logic [4:0]  rd;
    for (int k = 0; k < 2; k++) begin
      rd  = 5'($urandom_range(1, 7));
      ins = {(k == 0) ? 6'h3F : 6'h00, rd, 21'($urandom)};
      step(ins, 0, 0, e, o);
      checks++;
      if (o.op !== 6'h00 || o.lat != 4 || o.retires != 1 || o.iaddr !== e.pc) begin
        errors++; $display("FAIL noop_%0d: got op=%h lat=%0d retires=%0d pc=%h want 00/4/1/%h",
                           k, o.op, o.lat, o.retires, o.iaddr, e.pc);
      end
      step({6'h10, 5'd9, rd, 16'h0}, 0, 0, e, o);
      checks++;
      if (o.a !== e.a || o.iaddr !== e.pc) begin
        errors++; $display("FAIL noop_%0d_regs: got R%0d=%h pc=%h want %h/%h", k, rd, o.a, o.iaddr, e.a, e.pc);
      end
    end
  endtask

  function automatic logic [5:0] pick_op(input int k);
    case (k)
      0: pick_op = 6'h10;  1: pick_op = 6'h12;  2: pick_op = 6'h13;  3: pick_op = 6'h14;
      4: pick_op = 6'h15;  5: pick_op = 6'h32;  6: pick_op = 6'h33;  7: pick_op = 6'h34;
      8: pick_op = 6'h35;  9: pick_op = 6'h39; 10: pick_op = 6'h3B; 11: pick_op = 6'h3C;
      12: pick_op = 6'h20; 13: pick_op = 6'h00; 14: pick_op = 6'h3F; default: pick_op = 6'h39;
    endcase
  endfunction

  task automatic test_random();
    exp_t e; obs_t o;
    logic [31:0] ins;
    int iw, dw, want_lat;
    for (int n = 0; n < 200; n++) begin
      ins = {pick_op($urandom_range(0, 16)), 2'b00, 3'($urandom), 2'b00, 3'($urandom), 16'($urandom)};
      if (ins[31:26] inside {6'h3B, 6'h3C}) ins[15:8] = 8'($urandom_range(0, 3));
      else if (ins[31:30] == 2'b01) ins[15:14] = 2'b00;
      iw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      step(ins, iw, dw, e, o);
      want_lat = 4 + iw + (e.mem ? dw + 1 : 0);
      checks++;
      if (!o.ok || o.lat != want_lat || o.retires != 1) begin
        errors++; $display("FAIL rnd%0d_timing ins=%h: got lat=%0d retires=%0d want %0d/1", n, ins, o.lat, o.retires, want_lat);
      end
      checks++;
      if (o.iaddr !== e.pc || o.pc !== e.pc || !o.stable || o.leak) begin
        errors++; $display("FAIL rnd%0d_fetch ins=%h: got addr=%h pc=%h stable=%0d leak=%0d want %h/%h/1/0",
                           n, ins, o.iaddr, o.pc, o.stable, o.leak, e.pc, e.pc);
      end
      checks++;
      if (o.op !== e.op || o.a !== e.a || o.b !== e.b) begin
        errors++; $display("FAIL rnd%0d_exec ins=%h: got op=%h a=%h b=%h want %h/%h/%h", n, ins, o.op, o.a, o.b, e.op, e.a, e.b);
      end
      if (e.mem) begin
        checks++;
        if (o.dreq != dw + 1 || o.we !== e.we || o.daddr !== e.daddr || (e.we && o.wd !== e.wd)) begin
          errors++; $display("FAIL rnd%0d_mem ins=%h: got cycles=%0d we=%b addr=%h wdata=%h want %0d/%b/%h/%h",
                             n, ins, o.dreq, o.we, o.daddr, o.wd, dw + 1, e.we, e.daddr, e.wd);
        end
      end else begin
        checks++;
        if (o.dreq != 0) begin errors++; $display("FAIL rnd%0d_nomem ins=%h: got %0d dmem cycles want 0", n, ins, o.dreq); end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o;
    int t = 0;
    while (imem_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    imem_ack  = 1'b1;
    imem_data = {6'h3B, 5'd7, 5'd0, 16'h0020};
    @(negedge clk);
    imem_ack = 1'b0;
    t = 0;
    while (dmem_req !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req: got %b want 1", dmem_req); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, alu_op, alu_a, alu_b, retire, pc} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got dreq=%b daddr=%h imem_req=%b pc=%h want all 0",
                         dmem_req, dmem_addr, imem_req, pc);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step({6'h10, 5'd9, 5'd7, 16'h0}, 0, 0, e, o);
    checks++;
    if (o.iaddr !== 32'd0 || o.a !== 32'd0 || o.lat != 4) begin
      errors++; $display("FAIL mid_reset_restart: got pc=%h R7=%h lat=%0d want 0/0/4", o.iaddr, o.a, o.lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dm[i]  = $urandom;
      mdm[i] = dm[i];
    end
    model_reset();
    test_reset();
    test_li();
    test_alu_ops();
    test_branch();
    test_mem();
    test_noop();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control unit that drives the CPU's 6-bit-opcode ALU from the other side of its interface. It fetches 32-bit instructions over a request/acknowledge port and decodes the opcode into `alu_op`. It supplies the `r2`/`r3` operands from an internal register file, captures the ALU result and `zero` flag, and then performs write-back, data-memory access or branch. The ALU is instantiated alongside it at CPU top level, purely combinational.

## Interface
Parameters:
- `DW`, 32, datapath / register / address width
- `NREG`, 32, register count (5-bit specifiers)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  DW  fetch word address (= PC)
- `imem_ack`  in  1  fetch data valid
- `imem_data`  in  DW  instruction word
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  DW  data word address
- `dmem_wdata`  out  DW  store data
- `dmem_ack`  in  1  access complete / load data valid
- `dmem_rdata`  in  DW  load data
- `alu_op`  out  6  to ALU `alu_op`
- `alu_a`  out  DW  to ALU `r2`
- `alu_b`  out  DW  to ALU `r3`
- `alu_r`  in  DW  from ALU `r1`
- `alu_zero`  in  1  from ALU `zero`
- `retire`  out  1  one-cycle pulse per completed instruction
- `pc`  out  DW  current PC

## Operation
- Instruction fields:
  - op = [31:26], rd = [25:21], rs = [20:16], rt = [15:11]
  - imm = [15:0]; sext = sign-extended, zext = zero-extended
- Operand selection, by opcode:
  - 010000 MOVE: a=R[rs]
  - 010010/010011/010100/010101 ADD/SUB/OR/AND: a=R[rs], b=R[rt]
  - 110010–110101 immediate forms: a=R[rs], b=sext(imm)
  - 111001 LI: b=sext(imm)
  - 111011 LWI: a=zext(imm), result is the load address
  - 111100 SWI: a=zext(imm) is the store address, store data = R[rd]
  - 100000 BEQ: a=R[rd], b=R[rs]
  - 000000 and every undefined opcode: NOOP, no register write
- Write-back: R[rd] <= latched result for MOVE/ALU/imm/LI, R[rd] <= dmem_rdata for LWI. All registers, including R0, are writable.
- PC update: pc <= pc+1, except BEQ with latched zero=1, where pc <= pc+1+sext(imm). Arithmetic is mod 2^DW and wraps silently.
- States: RESET, FETCH, DECODE, EXEC, MEM, WB.
  - RESET → FETCH unconditionally.
  - FETCH waits for imem_ack, latches IR, then → DECODE.
  - DECODE → EXEC.
  - EXEC → MEM for LWI/SWI, else → WB.
  - MEM waits for dmem_ack, then → WB.
  - WB → FETCH.
- Register read happens in DECODE; operands are held in A/B latches.
- `alu_op`, `alu_a` and `alu_b` carry the decoded values only in EXEC and are 0 in every other state. The result and zero flag are registered at the end of EXEC.

## Timing
- While rst=1: state RESET, pc=0, all registers 0, every output 0 (retire=0, alu_op=000000).
- First imem_req occurs in the second cycle after rst deasserts (one RESET cycle).
- FETCH handshake:
  - imem_req=1 with imem_addr=pc, held stable until a cycle with imem_ack=1 sampled.
  - imem_req drops the following cycle.
  - An ack in the same cycle as the request is legal.
- MEM handshake: same rules as FETCH. dmem_rdata is sampled in the ack cycle.
- Latency with zero-wait memories:
  - ALU ops, BEQ, NOOP: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LWI/SWI: 5 cycles.
  - Each wait cycle adds one.
- retire=1 only in the WB cycle; pc updates at the end of WB.
- A register written in WB is visible to the next instruction's DECODE. No hazards are possible.
- Acks arriving outside FETCH/MEM are ignored.
- Reset mid-instruction abandons it at once: outputs drop asynchronously and nothing is written. An outstanding memory request is dropped, and the memory side must tolerate this.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants (NOOP, MOVE, ADD, SUB, OR, AND, ADDI…ANDI, BEQ, LI, LWI, SWI)
  - the state enumeration
  - the instruction field bit positions
- Sub-module `cpu_regfile`: NREG×DW, two combinational read ports, one synchronous write port, asynchronous clear on rst.

## Test plan
- Reset then LI R1,0x0005 with zero-wait memory:
  - imem_addr=0, then retire at cycle 4.
  - In EXEC: alu_op=111001, alu_b=0x00000005.
  - Afterwards R1=5, pc=1.
- With R1=5, R2=3:
  - SUB R3,R1,R2 → alu_a=5, alu_b=3, R3=2.
  - ANDI R4,R1,0xFFFC → alu_b=0xFFFFFFFC, R4=4.
- BEQ R1,R5,+4 at pc=10 with R1=R5=7 → pc=15.
  - With R5=8 → pc=11.
  - Offset 0xFFFF with equal operands → pc=10.
- SWI R1,0x0020 then LWI R6,0x0020 against a 3-wait-cycle memory:
  - dmem_req held for 4 cycles with dmem_we=1, addr=0x20, wdata=5.
  - Load yields R6=5.
  - Each instruction takes 8 cycles.
- Opcode 0x3F, then 000000 → no register change, pc +1 each, one retire pulse each.
- rst asserted during a MEM wait of LWI R7 → all outputs 0 immediately, R7 unchanged (0), restart fetch at pc=0.
